// File: rtl/lcd_cmd_sched_if.sv
// Handshake bundle between host, scheduler and LCD controller.
//   master : host/controller side (drives command offer and controller status)
//   slave  : scheduler side (drives host_ready and the command strobe)
interface lcd_cmd_sched_if;
  logic [2:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic       lcd_busy;
  logic       lcd_done;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;

  modport master (
    output host_cmd, host_valid, lcd_busy, lcd_done,
    input  host_ready, lcd_cmd, lcd_cmd_valid
  );

  modport slave (
    input  host_cmd, host_valid, lcd_busy, lcd_done,
    output host_ready, lcd_cmd, lcd_cmd_valid
  );
endinterface

// File: rtl/lcd_cmd_sched.sv
// LCD command scheduler: buffers host commands in a small FIFO, waits for the
// controller's image-load phase, then issues one command per idle cycle until
// the write-back command, after which it parks until the controller is done.
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   bus          - host valid/ready command port and controller command strobe
//   fifo_level   - current FIFO occupancy
//   issued_cnt   - saturating count of commands issued since reset
//   sched_state  - 0 WAIT_INIT, 1 RUN, 2 WB_WAIT, 3 FIN
module lcd_cmd_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  lcd_cmd_sched_if.slave           bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [1:0]               sched_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_RUN       = 2'd1,
    ST_WB_WAIT   = 2'd2,
    ST_FIN       = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_lcd_cmd;
  logic            r_lcd_cmd_valid;

  logic            w_full;
  logic            w_empty;
  logic [2:0]      w_head;
  logic            w_ready;
  logic            w_issue;
  logic            w_flush;
  logic            w_push;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Next state, accept window and issue decision
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_issue     = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_WAIT_INIT: begin
        w_ready = !w_full;
        if (!bus.lcd_busy) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_ready = !w_full;
        if (!w_empty && !bus.lcd_busy) begin
          w_issue = 1'b1;
          if (w_head == 3'd0) w_state_nxt = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        if (bus.lcd_done) begin
          w_state_nxt = ST_FIN;
          w_flush     = 1'b1;
        end
      end
      ST_FIN: begin
      end
    endcase
  end

  // Ready is gated by reset so it reads 0 while reset is held
  assign w_push         = bus.host_valid & w_ready;
  assign bus.host_ready = reset & w_ready;

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.host_cmd;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_WAIT_INIT;
    else        r_state <= w_state_nxt;
  end

  // FIFO pointers, level, command strobe and issue counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_cnt           <= '0;
      r_lcd_cmd       <= 3'd0;
      r_lcd_cmd_valid <= 1'b0;
    end else begin
      r_lcd_cmd_valid <= w_issue;
      if (w_issue) r_lcd_cmd <= w_head;
      if (w_issue && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push)  r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_issue})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

  assign bus.lcd_cmd       = r_lcd_cmd;
  assign bus.lcd_cmd_valid = r_lcd_cmd_valid;
  assign fifo_level        = r_level;
  assign issued_cnt        = r_cnt;
  assign sched_state       = r_state;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed testbench for lcd_cmd_sched (DEPTH=4, CNT_W=8).
module tb_lcd_cmd_sched;

  logic       clk;
  logic       reset;
  logic [2:0] fifo_level;
  logic [7:0] issued_cnt;
  logic [1:0] sched_state;
  int         n_checks;
  int         n_errors;

  lcd_cmd_sched_if bus ();

  lcd_cmd_sched #(.DEPTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .issued_cnt  (issued_cnt),
    .sched_state (sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic busy);
    bus.host_valid = 1'b0;
    bus.host_cmd   = 3'd0;
    bus.lcd_done   = 1'b0;
    bus.lcd_busy   = busy;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  // Reset, enter RUN, then hold the controller busy
  task automatic go_run_busy();
    do_reset(1'b0);
    bus.lcd_busy = 1'b1;
  endtask

  task automatic push(input logic [2:0] c);
    bus.host_valid = 1'b1;
    bus.host_cmd   = c;
    tick();
    bus.host_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.host_valid = 1'b0;
    bus.host_cmd   = 3'd0;
    bus.lcd_done   = 1'b0;
    bus.lcd_busy   = 1'b1;
    reset = 1'b0;
    #3;
    n_checks++; if (bus.host_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %0b exp 0", bus.host_ready); end
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b exp 0", bus.lcd_cmd_valid); end
    n_checks++; if (bus.lcd_cmd !== 3'd0) begin n_errors++; $display("FAIL rst_cmd: got %0d exp 0", bus.lcd_cmd); end
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL rst_level: got %0d exp 0", fifo_level); end
    n_checks++; if (issued_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d exp 0", issued_cnt); end
    n_checks++; if (sched_state !== 2'd0) begin n_errors++; $display("FAIL rst_state: got %0d exp 0", sched_state); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    n_checks++; if (sched_state !== 2'd0) begin n_errors++; $display("FAIL rst_hold_state: got %0d exp 0", sched_state); end
    n_checks++; if (bus.host_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_after: got %0b exp 1", bus.host_ready); end
  endtask

  task automatic test_init_hold();
    logic saw;
    logic [2:0] exp_c [3];
    exp_c[0] = 3'd3; exp_c[1] = 3'd4; exp_c[2] = 3'd5;
    saw = 1'b0;
    do_reset(1'b1);
    push(3'd3); saw |= bus.lcd_cmd_valid;
    push(3'd4); saw |= bus.lcd_cmd_valid;
    push(3'd5); saw |= bus.lcd_cmd_valid;
    for (int i = 0; i < 67; i++) begin
      tick();
      saw |= bus.lcd_cmd_valid;
    end
    n_checks++; if (saw !== 1'b0) begin n_errors++; $display("FAIL init_no_strobe: got %0b exp 0", saw); end
    n_checks++; if (fifo_level !== 3'd3) begin n_errors++; $display("FAIL init_level: got %0d exp 3", fifo_level); end
    n_checks++; if (sched_state !== 2'd0) begin n_errors++; $display("FAIL init_state: got %0d exp 0", sched_state); end
    bus.lcd_busy = 1'b0;
    tick();
    n_checks++; if (sched_state !== 2'd1) begin n_errors++; $display("FAIL init_to_run: got %0d exp 1", sched_state); end
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL init_entry_no_issue: got %0b exp 0", bus.lcd_cmd_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== exp_c[i]) begin
        n_errors++; $display("FAIL init_strobe%0d: got valid=%0b cmd=%0d exp valid=1 cmd=%0d", i, bus.lcd_cmd_valid, bus.lcd_cmd, exp_c[i]);
      end
    end
    tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL init_strobe_end: got %0b exp 0", bus.lcd_cmd_valid); end
    n_checks++; if (issued_cnt !== 8'd3) begin n_errors++; $display("FAIL init_cnt: got %0d exp 3", issued_cnt); end
    n_checks++; if (bus.lcd_cmd !== 3'd5) begin n_errors++; $display("FAIL init_cmd_hold: got %0d exp 5", bus.lcd_cmd); end
  endtask

  task automatic test_full();
    logic [2:0] exp_c [5];
    logic [2:0] exp_l [5];
    exp_c[0] = 3'd1; exp_c[1] = 3'd2; exp_c[2] = 3'd6; exp_c[3] = 3'd7; exp_c[4] = 3'd3;
    exp_l[0] = 3'd3; exp_l[1] = 3'd3; exp_l[2] = 3'd2; exp_l[3] = 3'd1; exp_l[4] = 3'd0;
    go_run_busy();
    push(3'd1); push(3'd2); push(3'd6); push(3'd7);
    n_checks++; if (fifo_level !== 3'd4) begin n_errors++; $display("FAIL full_level: got %0d exp 4", fifo_level); end
    n_checks++; if (bus.host_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %0b exp 0", bus.host_ready); end
    bus.host_valid = 1'b1;
    bus.host_cmd   = 3'd3;
    tick();
    n_checks++; if (fifo_level !== 3'd4) begin n_errors++; $display("FAIL full_hold_level: got %0d exp 4", fifo_level); end
    bus.lcd_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) bus.host_valid = 1'b0;
      n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== exp_c[i] || fifo_level !== exp_l[i]) begin
        n_errors++; $display("FAIL full_drain%0d: got valid=%0b cmd=%0d level=%0d exp valid=1 cmd=%0d level=%0d", i, bus.lcd_cmd_valid, bus.lcd_cmd, fifo_level, exp_c[i], exp_l[i]);
      end
    end
    tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL full_end_valid: got %0b exp 0", bus.lcd_cmd_valid); end
  endtask

  task automatic test_stall();
    go_run_busy();
    push(3'd5); push(3'd6);
    n_checks++; if (fifo_level !== 3'd2 || bus.lcd_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL stall_setup: got level=%0d valid=%0b exp level=2 valid=0", fifo_level, bus.lcd_cmd_valid); end
    bus.lcd_busy = 1'b0; tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== 3'd5 || fifo_level !== 3'd1) begin n_errors++; $display("FAIL stall_issue0: got valid=%0b cmd=%0d level=%0d exp 1/5/1", bus.lcd_cmd_valid, bus.lcd_cmd, fifo_level); end
    bus.lcd_busy = 1'b1; tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0 || bus.lcd_cmd !== 3'd5 || fifo_level !== 3'd1) begin n_errors++; $display("FAIL stall_busy1: got valid=%0b cmd=%0d level=%0d exp 0/5/1", bus.lcd_cmd_valid, bus.lcd_cmd, fifo_level); end
    tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0 || issued_cnt !== 8'd1) begin n_errors++; $display("FAIL stall_busy2: got valid=%0b cnt=%0d exp 0/1", bus.lcd_cmd_valid, issued_cnt); end
    bus.lcd_busy = 1'b0; tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== 3'd6 || fifo_level !== 3'd0 || issued_cnt !== 8'd2) begin n_errors++; $display("FAIL stall_issue1: got valid=%0b cmd=%0d level=%0d cnt=%0d exp 1/6/0/2", bus.lcd_cmd_valid, bus.lcd_cmd, fifo_level, issued_cnt); end
  endtask

  task automatic test_wb();
    logic saw;
    go_run_busy();
    push(3'd5); push(3'd0); push(3'd2);
    bus.lcd_busy = 1'b0; tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== 3'd5) begin n_errors++; $display("FAIL wb_first: got valid=%0b cmd=%0d exp 1/5", bus.lcd_cmd_valid, bus.lcd_cmd); end
    tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== 3'd0 || sched_state !== 2'd2) begin n_errors++; $display("FAIL wb_issue: got valid=%0b cmd=%0d state=%0d exp 1/0/2", bus.lcd_cmd_valid, bus.lcd_cmd, sched_state); end
    n_checks++; if (bus.host_ready !== 1'b0 || fifo_level !== 3'd1) begin n_errors++; $display("FAIL wb_ready_level: got ready=%0b level=%0d exp 0/1", bus.host_ready, fifo_level); end
    bus.host_valid = 1'b1; bus.host_cmd = 3'd4;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw |= bus.lcd_cmd_valid;
    end
    bus.host_valid = 1'b0;
    n_checks++; if (saw !== 1'b0 || fifo_level !== 3'd1 || sched_state !== 2'd2) begin n_errors++; $display("FAIL wb_park: got strobe=%0b level=%0d state=%0d exp 0/1/2", saw, fifo_level, sched_state); end
    bus.lcd_done = 1'b1; tick();
    bus.lcd_done = 1'b0;
    n_checks++; if (sched_state !== 2'd3) begin n_errors++; $display("FAIL wb_fin: got %0d exp 3", sched_state); end
    tick();
    n_checks++; if (fifo_level !== 3'd0 || issued_cnt !== 8'd2 || bus.host_ready !== 1'b0 || bus.lcd_cmd_valid !== 1'b0) begin
      n_errors++; $display("FAIL wb_fin_state: got level=%0d cnt=%0d ready=%0b valid=%0b exp 0/2/0/0", fifo_level, issued_cnt, bus.host_ready, bus.lcd_cmd_valid);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int exp_v;
    logic [2:0] c;
    go_run_busy();
    push(3'd1); push(3'd2);
    q.push_back(1); q.push_back(2);
    bus.lcd_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      c = 3'(1 + ((i + 2) % 7));
      bus.host_valid = 1'b1;
      bus.host_cmd   = c;
      q.push_back(int'(c));
      tick();
      exp_v = q.pop_front();
      n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== 3'(exp_v) || fifo_level !== 3'd2) begin
        n_errors++; $display("FAIL b2b_iter%0d: got valid=%0b cmd=%0d level=%0d exp valid=1 cmd=%0d level=2", i, bus.lcd_cmd_valid, bus.lcd_cmd, fifo_level, exp_v);
      end
    end
    bus.host_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = q.pop_front();
      n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== 3'(exp_v)) begin
        n_errors++; $display("FAIL b2b_drain%0d: got valid=%0b cmd=%0d exp 1/%0d", i, bus.lcd_cmd_valid, bus.lcd_cmd, exp_v);
      end
    end
    tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0 || fifo_level !== 3'd0 || issued_cnt !== 8'd12) begin
      n_errors++; $display("FAIL b2b_end: got valid=%0b level=%0d cnt=%0d exp 0/0/12", bus.lcd_cmd_valid, fifo_level, issued_cnt);
    end
  endtask

  task automatic test_async_reset();
    go_run_busy();
    push(3'd4);
    bus.lcd_busy = 1'b0; tick();
    n_checks++; if (bus.lcd_cmd_valid !== 1'b1 || bus.lcd_cmd !== 3'd4) begin n_errors++; $display("FAIL arst_pre: got valid=%0b cmd=%0d exp 1/4", bus.lcd_cmd_valid, bus.lcd_cmd); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.lcd_cmd_valid !== 1'b0 || bus.lcd_cmd !== 3'd0 || issued_cnt !== 8'd0 || sched_state !== 2'd0 || bus.host_ready !== 1'b0) begin
      n_errors++; $display("FAIL arst_strobe: got valid=%0b cmd=%0d cnt=%0d state=%0d ready=%0b exp 0/0/0/0/0", bus.lcd_cmd_valid, bus.lcd_cmd, issued_cnt, sched_state, bus.host_ready);
    end
    bus.lcd_busy = 1'b1;
    #3 reset = 1'b1;
    tick();
    n_checks++; if (sched_state !== 2'd0 || issued_cnt !== 8'd0) begin n_errors++; $display("FAIL arst_release: got state=%0d cnt=%0d exp 0/0", sched_state, issued_cnt); end
    push(3'd7); push(3'd7);
    #3 reset = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL arst_level: got %0d exp 0", fifo_level); end
    #2 reset = 1'b1;
    tick();
    n_checks++; if (sched_state !== 2'd0 || fifo_level !== 3'd0) begin n_errors++; $display("FAIL arst_after: got state=%0d level=%0d exp 0/0", sched_state, fifo_level); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_init_hold();
    test_full();
    test_stall();
    test_wb();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sched.md
# lcd_cmd_sched

Command scheduler that sits between a host command source and the LCD image controller (8x8 image buffer, 2x2 operation window, write-back to IRB). It accepts host commands through a valid/ready handshake and buffers them in a small FIFO. It waits for the controller to finish its image-load phase, then issues commands one per cycle while the controller is not busy. After the write-back command it stops issuing and parks until the controller reports `done`.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, minimum 2
- `CNT_W`, 8, width of issued-command counter
- `clk`  input  1  single clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low; 0 forces reset state immediately
- `host_cmd`  input  3  command code: 0 write-back, 1 up, 2 down, 3 left, 4 right, 5 average, 6 mirror-X, 7 mirror-Y
- `host_valid`  input  1  host offers `host_cmd`
- `host_ready`  output  1  scheduler accepts `host_cmd` this cycle
- `lcd_busy`  input  1  controller busy flag
- `lcd_done`  input  1  controller finished write-back
- `lcd_cmd`  output  3  command to controller
- `lcd_cmd_valid`  output  1  one-cycle strobe qualifying `lcd_cmd`
- `fifo_level`  output  log2(DEPTH)+1  current FIFO occupancy
- `issued_cnt`  output  CNT_W  commands issued since reset, saturating
- `sched_state`  output  2  state: 0 WAIT_INIT, 1 RUN, 2 WB_WAIT, 3 FIN

## Operation
- Reset values: `host_ready`=0, `lcd_cmd`=0, `lcd_cmd_valid`=0, `fifo_level`=0, `issued_cnt`=0, `sched_state`=WAIT_INIT. FIFO pointers are cleared and contents are don't-care.
- Push: occurs on a rising edge when `host_valid` and `host_ready` are both 1. `host_ready` = (fifo not full) and (state is WAIT_INIT or RUN). It is combinational from registered state and level.
- Full is judged on the current level only. A pop in the same cycle does not re-open `host_ready`.
- FSM:
  - WAIT_INIT -> RUN when `lcd_busy`=0 is sampled. Pushes are allowed in WAIT_INIT; nothing is issued.
  - RUN: issue when FIFO is non-empty and `lcd_busy`=0. On issue, the head is popped, `lcd_cmd`<=head, `lcd_cmd_valid`<=1 for exactly one cycle, and `issued_cnt`+=1 (saturates at 2^CNT_W-1).
  - RUN -> WB_WAIT on the edge that issues code 0. Entries behind it stay in the FIFO, unissued.
  - WB_WAIT: no issue, no push. -> FIN when `lcd_done`=1 is sampled.
  - FIN: terminal until reset. The FIFO is flushed on entry, so `fifo_level`=0 one cycle after entering FIN. `host_ready`=0.
- Back-to-back issue is allowed: one command per cycle while `lcd_busy`=0 and the FIFO is non-empty.
- A push and a pop on the same edge leave `fifo_level` unchanged. The FIFO is first-word-fall-through internally. Read and write pointers wrap modulo DEPTH.
- `lcd_busy`=1 in RUN stalls issue, retains the head, and leaves counters unchanged.
- `lcd_done` seen in WAIT_INIT or RUN is ignored.

## Timing
- Minimum latency: command pushed at edge k; `lcd_cmd_valid`=1 during the cycle after edge k+1. This holds if state is RUN and `lcd_busy`=0.
- `lcd_cmd` holds its last issued value after the strobe drops. `lcd_cmd_valid` is never high for 2 cycles for the same entry.
- WAIT_INIT -> RUN takes 1 cycle after the first low `lcd_busy` sample. The first issue can occur on the same edge that enters RUN only if already in RUN; otherwise it occurs on the next edge.
- Reset asserted mid-operation, including during a strobe: `lcd_cmd_valid` drops asynchronously to 0, the FIFO empties, and state returns to WAIT_INIT.

## Test plan
- Init hold:
  - Stimulus: `lcd_busy`=1 for 70 cycles; push 3,4,5 during that time.
  - Required: `lcd_cmd_valid` stays 0 and `fifo_level`=3.
  - After `lcd_busy` falls: strobes 3,4,5 on three consecutive cycles, `issued_cnt`=3.
- Full FIFO:
  - Stimulus: DEPTH=4, `lcd_busy`=1 in RUN, push 1,2,6,7, then hold `host_valid`=1.
  - Required: `host_ready`=0 while `fifo_level`=4. Release busy: order 1,2,6,7, and the 5th command is accepted only after a pop.
- Stall:
  - Stimulus: in RUN with 2 entries, toggle `lcd_busy` 0,1,1,0.
  - Required: one issue per cycle with busy low, none with busy high, order preserved.
- Write-back stop:
  - Stimulus: queue 5,0,2.
  - Required: 5 then 0 issued; state WB_WAIT; 2 never issued; `host_ready`=0.
  - On `lcd_done`=1: FIN, `fifo_level`=0 next cycle, `issued_cnt`=2.
- Simultaneous push/pop:
  - Stimulus: level 2, push and issue on the same edge.
  - Required: level stays 2, pointers wrap correctly over 10 iterations, FIFO order intact.
- Async reset:
  - Stimulus: assert `reset`=0 mid-strobe and between edges.
  - Required: all outputs immediately at reset values. After release, WAIT_INIT, `issued_cnt`=0.
